// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: pattern table (g..a, active-low) and the blank code.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Entries 10-15 are the A-F glyphs; the decoder substitutes blank when hex is off.
    localparam seg_t SEG_DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational code-to-segment lookup with hex enable and forced blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DEC[code];
        if (blank || (!hex_en && code > 4'd9))
            seg = SEG_BLANK;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: prescaled digit slots, anti-ghost gap,
// frame-synchronous double-buffered data and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GAP        = 2,
    parameter bit HEX_EN     = 1'b0
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iLOAD,
    input  logic                    iBLANK_LZ,
    output logic [6:0]              oSEG,
    output logic                    oDP,
    output logic [NUM_DIGITS-1:0]   oAN,
    output logic                    oFRAME
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          pre_last;
    logic          idx_wrap;

    logic [NUM_DIGITS-1:0][3:0] shadow_data, act_data;
    logic [NUM_DIGITS-1:0]      shadow_dp, act_dp;
    logic                       pending;

    logic [NUM_DIGITS-1:0] zero_run;
    logic [3:0]            sel_code;
    logic                  sel_blank;
    logic                  in_gap;
    seg_t                  dec_seg;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign pre_last = (presc == PRE_LAST);
    assign idx_wrap = pre_last && (idx == IDX_LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= pre_last ? '0 : presc + 1'b1;
            if (pre_last)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Active data only changes at the frame wrap; a load landing on the wrap bypasses the shadow.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            pending     <= 1'b0;
        end else begin
            if (iLOAD) begin
                shadow_data <= iDATA;
                shadow_dp   <= iDP;
            end
            if (idx_wrap) begin
                if (iLOAD) begin
                    act_data <= iDATA;
                    act_dp   <= iDP;
                end else if (pending) begin
                    act_data <= shadow_data;
                    act_dp   <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (iLOAD) begin
                pending <= 1'b1;
            end
        end
    end

    // zero_run[k]: digit k and every digit above it are zero.
    always_comb begin
        logic run;
        run      = 1'b1;
        zero_run = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run         = run && (act_data[k] == 4'd0);
            zero_run[k] = run;
        end
    end

    assign sel_code  = act_data[idx];
    assign sel_blank = iBLANK_LZ && (idx != '0) && zero_run[idx];

    generate
        if (GAP > 0) begin : g_gap
            assign in_gap = (presc < PW'(GAP));
        end else begin : g_nogap
            assign in_gap = 1'b0;
        end
    endgenerate

    seg7_decode u_dec (
        .code   (sel_code),
        .hex_en (HEX_EN),
        .blank  (sel_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        an_nxt = '1;
        if (!in_gap)
            an_nxt[idx] = 1'b0;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSEG   <= SEG_BLANK;
            oDP    <= 1'b1;
            oAN    <= '1;
            oFRAME <= 1'b0;
        end else begin
            oSEG   <= in_gap ? SEG_BLANK : dec_seg;
            oDP    <= in_gap | ~act_dp[idx];
            oAN    <= an_nxt;
            oFRAME <= idx_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: expected digit slots are queued per frame, a monitor pops them at each slot start.
module tb_seg7_scan_driver;

    logic        iCLK = 1'b0;
    logic        iRST, iLOAD, iBLANK_LZ;
    logic [15:0] iDATA;
    logic [3:0]  iDP;
    logic [6:0]  oSEG, oSEG_h;
    logic        oDP, oDP_h, oFRAME, oFRAME_h;
    logic [3:0]  oAN, oAN_h;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] segh;
        logic       dp;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   errs   = 0;
    int   checks = 0;

    always #5 iCLK = ~iCLK;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .GAP(1), .HEX_EN(1'b0)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDP(iDP), .iLOAD(iLOAD),
        .iBLANK_LZ(iBLANK_LZ), .oSEG(oSEG), .oDP(oDP), .oAN(oAN), .oFRAME(oFRAME)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .GAP(1), .HEX_EN(1'b1)) dut_hex (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDP(iDP), .iLOAD(iLOAD),
        .iBLANK_LZ(iBLANK_LZ), .oSEG(oSEG_h), .oDP(oDP_h), .oAN(oAN_h), .oFRAME(oFRAME_h)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // segs/segh packed {d3,d2,d1,d0}; dpn bit k is the expected oDP in digit k's slot
    task automatic push_frame(input logic [27:0] segs, input logic [27:0] segh, input logic [3:0] dpn);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.an   = ~(4'b0001 << k);
            e.seg  = segs[k*7 +: 7];
            e.segh = segh[k*7 +: 7];
            e.dp   = dpn[k];
            q.push_back(e);
        end
    endtask

    task automatic wait_frame();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iCLK);
            got = oFRAME;
        end
        chk("frame_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        iDATA = d;
        iDP   = dp;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iLOAD = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seg"},   {25'd0, oSEG},   32'h7F);
        chk({tag, "_dp"},    {31'd0, oDP},    32'd1);
        chk({tag, "_an"},    {28'd0, oAN},    32'hF);
        chk({tag, "_frame"}, {31'd0, oFRAME}, 32'd0);
        chk({tag, "_hex_seg"}, {25'd0, oSEG_h}, 32'h7F);
        chk({tag, "_hex_frame"}, {31'd0, oFRAME_h}, 32'd0);
    endtask

    // Monitor: slot start = oAN leaving all-ones; gap cycles must be fully blank.
    initial begin
        logic [3:0] prev_an;
        int         run_len, since;
        bit         run_ok, have_fr;
        prev_an = '1; run_len = 0; since = 0; run_ok = 0; have_fr = 0;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                prev_an = '1;
                run_ok  = 0;
                have_fr = 0;
            end else begin
                since++;
                if (oFRAME) begin
                    if (have_fr)
                        chk("frame_period", since, 16);
                    have_fr = 1;
                    since   = 0;
                end
                if (oAN == 4'hF) begin
                    chk("gap_blank", {16'd0, oSEG, oDP, oSEG_h, oDP_h}, {16'd0, 7'h7F, 1'b1, 7'h7F, 1'b1});
                    if (prev_an != 4'hF && run_ok)
                        chk("slot_len", run_len, 3);
                end else if (prev_an == 4'hF) begin
                    run_len = 1;
                    run_ok  = 1;
                    if (q.size() > 0) begin
                        me = q.pop_front();
                        chk($sformatf("an_%h", me.an),     {28'd0, oAN},    {28'd0, me.an});
                        chk($sformatf("an_hex_%h", me.an), {28'd0, oAN_h},  {28'd0, me.an});
                        chk($sformatf("seg_%h", me.an),    {25'd0, oSEG},   {25'd0, me.seg});
                        chk($sformatf("seg_hex_%h", me.an),{25'd0, oSEG_h}, {25'd0, me.segh});
                        chk($sformatf("dp_%h", me.an),     {31'd0, oDP},    {31'd0, me.dp});
                    end
                end else begin
                    run_len++;
                end
                prev_an = oAN;
            end
        end
    end

    initial begin
        iRST = 1'b0; iLOAD = 1'b0; iDATA = '0; iDP = '0; iBLANK_LZ = 1'b0;
        #1 iRST = 1'b1;
        repeat (2) @(negedge iCLK);
        chk_reset_outputs("reset");
        #1 iRST = 1'b0;

        // first frame after reset shows zeros; 1234 loaded early appears next frame
        push_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        repeat (2) @(negedge iCLK);
        load(16'h1234, 4'h0);
        wait_frame();
        push_frame({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

        // two loads in one frame: old data holds, last load wins
        repeat (2) @(negedge iCLK);
        load(16'h0007, 4'h0);
        @(negedge iCLK);
        load(16'h0009, 4'h0);
        wait_frame();
        push_frame({7'h40, 7'h40, 7'h40, 7'h10}, {7'h40, 7'h40, 7'h40, 7'h10}, 4'hF);

        // pending 9999 overridden by a load on the exact wrap cycle (state prescaler=3, index=3)
        repeat (2) @(negedge iCLK);
        load(16'h9999, 4'h0);
        repeat (12) @(negedge iCLK);
        load(16'h0C21, 4'b0010);
        chk("wrap_load_frame", {31'd0, oFRAME}, 32'd1);
        push_frame({7'h40, 7'h7F, 7'h24, 7'h79}, {7'h40, 7'h46, 7'h24, 7'h79}, 4'b1101);
        wait_frame();
        push_frame({7'h40, 7'h7F, 7'h24, 7'h79}, {7'h40, 7'h46, 7'h24, 7'h79}, 4'b1101);

        // leading-zero suppression
        repeat (2) @(negedge iCLK);
        load(16'h0050, 4'h0);
        wait_frame();
        iBLANK_LZ = 1'b1;
        push_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
        repeat (2) @(negedge iCLK);
        load(16'h0000, 4'h0);
        wait_frame();
        push_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

        // asynchronous reset mid-slot with a load pending
        wait_frame();
        iBLANK_LZ = 1'b0;
        repeat (2) @(negedge iCLK);
        load(16'h8888, 4'hF);
        repeat (3) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1 chk_reset_outputs("async_rst");
        repeat (2) @(negedge iCLK);
        #1 iRST = 1'b0;
        push_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        wait_frame();
        push_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        wait_frame();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4; number of multiplexed digits; SHALL be legal from 1 to 8.
REQ-002 Parameter CLK_DIV, default 50000; iCLK cycles per digit slot; SHALL be at least 2.
REQ-003 Parameter GAP, default 2; anti-ghosting blank cycles at the start of each slot; SHALL satisfy 0 <= GAP < CLK_DIV.
REQ-004 Parameter HEX_EN, default 0; when 1, codes 10-15 display A-F; when 0, they display blank.
REQ-005 iCLK  input  1  the single clock; all state SHALL be clocked on the rising edge.
REQ-006 iRST  input  1  reset, asynchronous and active-high.
REQ-007 iDATA  input  4*NUM_DIGITS  digit codes; nibble k drives digit k; digit 0 is the least significant.
REQ-008 iDP  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-009 iLOAD  input  1  one-cycle strobe that captures iDATA and iDP.
REQ-010 iBLANK_LZ  input  1  leading-zero suppression enable, level-sensitive.
REQ-011 oSEG  output  7  segments g..a, active-low; bit 0 is segment a.
REQ-012 oDP  output  1  decimal point, active-low.
REQ-013 oAN  output  NUM_DIGITS  digit select, active-low, one-cold or all-high.
REQ-014 oFRAME  output  1  one-cycle pulse at each full-scan wrap.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; digit index SHALL advance on the cycle the prescaler reaches CLK_DIV-1, and wrap from NUM_DIGITS-1 to 0.
REQ-016 iLOAD SHALL write iDATA/iDP into a shadow register and set a pending flag.
REQ-017 On index wrap with pending set, active register SHALL take the shadow value and pending SHALL clear; display data SHALL never change mid-frame.
REQ-018 If iLOAD coincides with index wrap, active register SHALL take iDATA/iDP directly, and pending SHALL be left clear.
REQ-019 Repeated iLOAD within one frame: the last one SHALL win.
REQ-020 oFRAME SHALL be high for exactly one cycle, the cycle after the index wraps to 0.
REQ-021 oSEG/oDP/oAN SHALL be registered, with 1-cycle latency from the index/prescaler state.
REQ-022 While prescaler < GAP, oAN SHALL be all ones and oSEG/oDP SHALL be all ones.
REQ-023 Otherwise, oAN bit[index] SHALL be 0 and all other bits 1.
REQ-024 oSEG SHALL be the decode of active nibble[index]; oDP SHALL be the inverse of active iDP[index].
REQ-025 Decode 0-9 SHALL be: 40,79,24,30,19,12,02,78,00,10 (hex, g..a).
REQ-026 Decode 10-15 with HEX_EN=1 SHALL be: 08,03,46,21,06,0E; with HEX_EN=0 it SHALL be 7F.
REQ-027 With iBLANK_LZ=1, a digit k>0 SHALL be blanked (oSEG=7F) when it and every digit above it are zero.
REQ-028 Digit 0 SHALL never be suppressed; oDP SHALL be unaffected by suppression.

Reset
REQ-029 iRST high SHALL immediately force oSEG=7F, oDP=1, oAN=all ones and oFRAME=0, independent of iCLK.
REQ-030 iRST SHALL clear the prescaler, index, shadow, active and pending registers to zero.
REQ-031 Reset asserted mid-frame SHALL discard pending data.
REQ-032 After release, the first slot SHALL start at digit 0 with prescaler 0.

Structure
REQ-033 Segment pattern constants and the blank constant 7F SHALL reside in shared package seg7_pkg.
REQ-034 Code-to-segment mapping SHALL be one combinational sub-module, seg7_decode (inputs: code, hex enable, blank; output: 7-bit pattern).
REQ-035 Everything else SHALL be flat in seg7_scan_driver.

Verification (NUM_DIGITS=4, CLK_DIV=4, GAP=1 unless stated)
REQ-036 Reset release, iLOAD with iDATA=16'h1234 -> after the next wrap, each slot shows oAN=E/D/B/7 with oSEG=19/30/24/79 (digits 0..3), and oAN=F during gap cycles.
REQ-037 iLOAD 16'h0007 mid-frame, then iLOAD 16'h0009 same frame -> old data holds until wrap, then digit 0 shows 10.
REQ-038 iLOAD on the exact wrap cycle -> new data is visible in slot 0 of that frame; oFRAME pulses once every 16 cycles.
REQ-039 iBLANK_LZ=1, iDATA=16'h0050 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40; iDATA=0 -> only digit 0 shows 40.
REQ-040 Code C with HEX_EN=0 -> 7F; with HEX_EN=1 -> 46; iDP=4'b0010 -> oDP=0 only in the digit 1 slot.
REQ-041 iRST pulsed mid-slot with a load pending -> outputs blank asynchronously; after release, the display shows zeros and the pending data is lost.
